// File: rtl/burst_mem_responder.sv
// ---------------------------------------------------------------------------
// burst_mem_responder
//
// Stand-in for external physical memory behind the cacheline adapter. It
// serves one 32-byte (256-bit) line per transaction as four 64-bit beats.
// The first beat appears a programmable number of edges after the request is
// sampled. The line array lives inside this block, so a cache hierarchy can
// be simulated or emulated as a closed system.
//
// Parameters
//   LATENCY      edges from request sampling to the first beat (1..255)
//   DEPTH_LINES  number of 256-bit lines; power of two, at least 2
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   pmem_read       read request, held until the final beat
//   pmem_write      write request, held until the final beat
//   pmem_addr       line address; [4:0] ignored, upper bits alias
//   pmem_wdata      write beat k, valid during response cycle k
//   pmem_resp       high for one cycle per beat, four beats per transaction
//   pmem_rdata      read beat k during response cycle k, otherwise 0
//   protocol_error  sticky flag for abort or simultaneous read+write
// ---------------------------------------------------------------------------
module burst_mem_responder #(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_addr,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        protocol_error
);

  localparam int         IDX_W  = $clog2(DEPTH_LINES);
  // The WAIT counter is preloaded with LATENCY-1. Terminal count zero then
  // lands the WAIT->BURST transition exactly on edge E0+LATENCY.
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_GAP
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic               r_is_read;   // latched op; a read+write request is a read
  logic [IDX_W-1:0]   r_idx;       // latched line index
  logic [255:0]       r_buf;       // line buffer: read source / write assembly
  logic [7:0]         r_lat_cnt;
  logic [1:0]         r_beat;      // beat currently on the bus while in BURST
  logic               r_resp;
  logic [63:0]        r_rdata;
  logic               r_perr;

  // NOTE: the line array is deliberately left without a reset. Resetting a
  // memory turns it into a huge flop bank and prevents RAM inference. Its
  // contents are undefined until each line is first written.
  logic [255:0]       r_mem [DEPTH_LINES];

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_req_any;
  logic               w_req_held;
  logic               w_start;
  logic               w_abort;
  logic               w_cnt_dec;
  logic               w_last;
  logic               w_commit;
  logic               w_capture;
  logic [1:0]         w_beat_out;
  logic               w_resp_nxt;
  logic [63:0]        w_rdata_nxt;
  logic               w_unused_addr;

  assign w_idx      = pmem_addr[5 +: IDX_W];
  assign w_req_any  = pmem_read | pmem_write;
  // Only the request that started the transaction has to stay high. During
  // a read+write collision the initiator may drop the write request.
  assign w_req_held = r_is_read ? pmem_read : pmem_write;

  // Offset bits and aliasing upper bits do not take part in line selection.
  assign w_unused_addr = ^pmem_addr;

  // NOTE: every signal written in this block gets a default first. Any path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_cnt_dec   = 1'b0;
    w_last      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!w_req_held) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_lat_cnt == 8'd0) begin
          w_state_nxt = S_BURST;
        end else begin
          w_cnt_dec   = 1'b1;
        end
      end

      S_BURST: begin
        if (!w_req_held) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_beat == 2'd3) begin
          w_last      = 1'b1;
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        // One dead cycle. A request still held here is ignored and
        // resampled in IDLE on the following edge.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The beat that goes on the bus after this edge: 0 when entering BURST
  // from WAIT, otherwise the successor of the current beat.
  assign w_beat_out = (r_state == S_BURST) ? (r_beat + 2'd1) : 2'd0;

  // Outputs are computed one cycle early and registered. There is therefore
  // no combinational path from any input to pmem_resp or pmem_rdata.
  assign w_resp_nxt  = (w_state_nxt == S_BURST);
  assign w_rdata_nxt = (w_resp_nxt && r_is_read) ?
                       r_buf[{w_beat_out, 6'd0} +: 64] : 64'd0;

  // A write beat lands in the buffer at the edge that ends its cycle. The
  // final beat goes straight to the array together with the first three.
  assign w_capture = (r_state == S_BURST) && !r_is_read && !w_abort;
  assign w_commit  = w_last && !r_is_read;

  // -------------------------------------------------------------------------
  // Control and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update from the same pre-edge values, whatever order the
  // statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_is_read <= 1'b0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_lat_cnt <= 8'd0;
      r_beat    <= 2'd0;
      r_resp    <= 1'b0;
      r_rdata   <= 64'd0;
      r_perr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_resp_nxt ? w_beat_out : 2'd0;
      r_resp  <= w_resp_nxt;
      r_rdata <= w_rdata_nxt;

      if (w_start) begin
        r_is_read <= pmem_read;
        r_idx     <= w_idx;
        // Snapshot the array at the sampling edge. Read data is always
        // the line as it stood at E0.
        r_buf     <= r_mem[w_idx];
        r_lat_cnt <= LAT_M1;
      end else if (w_cnt_dec) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end

      if (w_capture) begin
        r_buf[{r_beat, 6'd0} +: 64] <= pmem_wdata;
      end

      if (w_abort || (w_start && pmem_read && pmem_write)) begin
        r_perr <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line array write port
  // -------------------------------------------------------------------------
  // w_commit decodes r_state, which is forced to IDLE while rst is high. A
  // reset in mid-burst therefore discards the write.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= {pmem_wdata, r_buf[191:0]};
    end
  end

  assign pmem_resp      = r_resp;
  assign pmem_rdata     = r_rdata;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_responder
//
// Scoreboard bench for two responder instances:
//   dut 0: LATENCY=8, DEPTH_LINES=4   (main flow, aliasing, errors, reset)
//   dut 1: LATENCY=1, DEPTH_LINES=256 (minimum latency, back-to-back)
// When a transaction is issued, run_txn pushes the expected beats, tagged
// with the clock edge that must precede each one. A separate monitor pops
// and compares on every negedge where pmem_resp is high. On negedges where
// pmem_resp is low, the monitor requires pmem_rdata to be zero.
// ---------------------------------------------------------------------------
module tb_burst_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        rd    = '0;
  logic [1:0]        wr    = '0;
  logic [1:0][31:0]  addr  = '0;
  logic [1:0][63:0]  wdata = '0;
  wire  [1:0]        resp;
  wire  [1:0][63:0]  rdata;
  wire  [1:0]        perr;

  burst_mem_responder #(.LATENCY(8), .DEPTH_LINES(4)) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .pmem_read      (rd[0]),
    .pmem_write     (wr[0]),
    .pmem_addr      (addr[0]),
    .pmem_wdata     (wdata[0]),
    .pmem_resp      (resp[0]),
    .pmem_rdata     (rdata[0]),
    .protocol_error (perr[0])
  );

  burst_mem_responder #(.LATENCY(1), .DEPTH_LINES(256)) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .pmem_read      (rd[1]),
    .pmem_write     (wr[1]),
    .pmem_addr      (addr[1]),
    .pmem_wdata     (wdata[1]),
    .pmem_resp      (resp[1]),
    .pmem_rdata     (rdata[1]),
    .protocol_error (perr[1])
  );

  // Beat 0 is the least-significant 64 bits of each line.
  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_B = {64'hB3B3_0000_0000_0004, 64'hB2B2_0000_0000_0003,
                                     64'hB1B1_0000_0000_0002, 64'hB0B0_0000_0000_0001};
  localparam logic [255:0] LINE_C = {64'hC0DE_0000_0000_00C3, 64'hC0DE_0000_0000_00C2,
                                     64'hC0DE_0000_0000_00C1, 64'hC0DE_0000_0000_00C0};
  localparam logic [255:0] LINE_D = {64'hD00D_0000_0000_00D3, 64'hD00D_0000_0000_00D2,
                                     64'hD00D_0000_0000_00D1, 64'hD00D_0000_0000_00D0};
  localparam logic [255:0] LINE_J = {4{64'hDEAD_BEEF_DEAD_BEEF}};

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          e;   // posedge number that precedes this beat
    logic [63:0] d;   // expected pmem_rdata
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int s, input int e, input logic [63:0] d);
    exp_t it;
    it.e = e;
    it.d = d;
    if (s == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  // Monitor: runs independently of stimulus.
  always @(negedge clk) begin
    exp_t it;
    bit   have;
    for (int s = 0; s < 2; s++) begin
      if (resp[s]) begin
        have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          check($sformatf("dut%0d unexpected_resp", s), 64'(resp[s]), 64'd0);
        end else begin
          if (s == 0) it = q0.pop_front();
          else        it = q1.pop_front();
          check($sformatf("dut%0d beat_edge", s), 64'(edge_cnt), 64'(it.e));
          check($sformatf("dut%0d beat_data", s), rdata[s], it.d);
        end
      end else begin
        check($sformatf("dut%0d rdata_idle", s), rdata[s], 64'd0);
      end
    end
  end

  // Issue one transaction on dut s; call right after a negedge.
  //   drop_k < 4 : drop the request during beat drop_k (abort)
  //   rst_k  < 4 : pulse rst during beat rst_k
  // A normal transaction drops its request after the final beat. It returns
  // at the negedge after E0+LAT+5, so the caller can re-assert at once and
  // be sampled at E0+LAT+6.
  task automatic run_txn(input int s, input bit do_rd, input bit do_wr,
                         input logic [31:0] a, input logic [255:0] wline,
                         input logic [255:0] exp_line, input int drop_k, input int rst_k);
    int lat;
    int e0;
    int nb;
    int n;
    lat = (s == 0) ? 8 : 1;
    n   = -100;
    rd[s]    = do_rd;
    wr[s]    = do_wr;
    addr[s]  = a;
    wdata[s] = '0;
    e0 = edge_cnt + 1;
    nb = 4;
    if (drop_k < 4) nb = drop_k + 1;
    if (rst_k  < 4) nb = rst_k + 1;
    for (int k = 0; k < nb; k++)
      push_exp(s, e0 + lat + k, do_rd ? exp_line[64*k +: 64] : 64'd0);
    for (int i = 0; i < lat + 10; i++) begin
      @(negedge clk);
      n = edge_cnt - e0 - lat;
      if (n >= 0 && n < 4) wdata[s] = wline[64*n +: 64];
      if (n == drop_k) begin
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        @(negedge clk);
        return;
      end
      if (n == rst_k) begin
        #2 rst = 1'b1;
        #1;
        check($sformatf("dut%0d resp_in_reset", s), 64'(resp[s]), 64'd0);
        check($sformatf("dut%0d rdata_in_reset", s), rdata[s], 64'd0);
        check($sformatf("dut%0d perr_in_reset", s), 64'(perr[s]), 64'd0);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (n == 4) begin
        rd[s] = 1'b0;
        wr[s] = 1'b0;
      end
      if (n == 5) return;
    end
    check($sformatf("dut%0d txn_timeout", s), 64'(n), 64'd5);
  endtask

  initial begin
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("dut%0d reset_resp", s), 64'(resp[s]), 64'd0);
      check($sformatf("dut%0d reset_rdata", s), rdata[s], 64'd0);
      check($sformatf("dut%0d reset_perr", s), 64'(perr[s]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write then read line 0x40 (index 2).
    run_txn(0, 1'b0, 1'b1, 32'h0000_0040, LINE_A, '0, 4, 4);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 4, 4);
    check("dut0 perr_clean", 64'(perr[0]), 64'd0);

    // Aliasing and offset, issued back-to-back: 0x20, 0xA7, 0x1234_5620 are all index 1.
    run_txn(0, 1'b0, 1'b1, 32'h0000_0020, LINE_B, '0, 4, 4);
    run_txn(0, 1'b1, 1'b0, 32'h0000_00A7, '0, LINE_B, 4, 4);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 4, 4);
    run_txn(0, 1'b1, 1'b0, 32'h1234_5620, '0, LINE_B, 4, 4);
    repeat (3) @(negedge clk);
    check("dut0 perr_still_clean", 64'(perr[0]), 64'd0);

    // Read and write together: the read wins and protocol_error is set.
    run_txn(0, 1'b1, 1'b1, 32'h0000_0040, LINE_J, LINE_A, 4, 4);
    check("dut0 perr_both", 64'(perr[0]), 64'd1);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 4, 4);

    // Abort a write during beat 2: the line is unchanged.
    run_txn(0, 1'b0, 1'b1, 32'h0000_0020, LINE_C, '0, 2, 4);
    check("dut0 perr_abort", 64'(perr[0]), 64'd1);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0020, '0, LINE_B, 4, 4);
    repeat (4) @(negedge clk);
    check("dut0 perr_sticky", 64'(perr[0]), 64'd1);

    // Reset during beat 1 of a write: the write is discarded.
    run_txn(0, 1'b0, 1'b1, 32'h0000_0040, LINE_D, '0, 4, 1);
    check("dut0 perr_after_rst", 64'(perr[0]), 64'd0);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_A, 4, 4);

    // LATENCY=1: write, then two back-to-back reads (0xFFFF_E04F aliases index 2).
    run_txn(1, 1'b0, 1'b1, 32'h0000_0040, LINE_C, '0, 4, 4);
    run_txn(1, 1'b1, 1'b0, 32'h0000_0040, '0, LINE_C, 4, 4);
    run_txn(1, 1'b1, 1'b0, 32'hFFFF_E04F, '0, LINE_C, 4, 4);
    check("dut1 perr_clean", 64'(perr[1]), 64'd0);

    repeat (4) @(negedge clk);
    check("dut0 beats_outstanding", 64'(q0.size()), 64'd0);
    check("dut1 beats_outstanding", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
